axi_lite_mst: RTL and testbench
===============================

Name: axi_lite_mst

Overview:
- AXI4-Lite master (initiator). Converts single-beat commands from a simple local command/response port into AXI-Lite write or read transactions.
- Sits on the initiator side of the AXI-Lite slave bridges (e.g. the EEPROM bridge) so that controller logic and testbenches can drive the bus without a CPU.
- Handles one outstanding transaction at a time: write (AW+W then B) or read (AR then R).

Parameters:
- BW, 32, data width of WDATA/RDATA and the command data.
- AW, 32, address width of AWADDR/ARADDR and the command address.
- TIMEOUT_CYC, 1024, watchdog limit in clk cycles (used only when AXI_LITE_MST_TIMEOUT_EN is defined).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- cmd_write_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  AW  target address.
- cmd_wdata_i  in  BW  write data.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  BW  read data; '0 for writes.
- rsp_resp_o  out  2  BRESP/RRESP as returned by the slave.
- rsp_timeout_o  out  1  watchdog abort flag (tied 0 when the feature is off).
- AWVALID_o out 1, AWREADY_i in 1, AWADDR_o out AW  write address channel.
- WVALID_o out 1, WREADY_i in 1, WDATA_o out BW, WSTRB_o out BW/8  write data channel.
- BVALID_i in 1, BREADY_o out 1, BRESP_i in 2  write response channel.
- ARVALID_o out 1, ARREADY_i in 1, ARADDR_o out AW  read address channel.
- RVALID_i in 1, RREADY_o out 1, RDATA_i in BW, RRESP_i in 2  read data channel.

Behaviour:
- Reset: all VALID/READY outputs 0, cmd_ready_o 0, rsp_valid_o 0, address/data/rsp outputs '0, FSM in IDLE. Reset mid-transaction drops everything immediately; no completion is reported.
- All outputs are registered.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: cmd_ready_o=1.
  - On cmd_valid_i: latch addr/data, clear the aw_done/w_done flags, clear the watchdog.
  - Go to WR_REQ if cmd_write_i, else RD_REQ.
  - Next cycle: AWVALID_o=WVALID_o=1 (write) or ARVALID_o=1 (read).
- WR_REQ:
  - AW and W are independent. Each VALID stays high until its own READY is sampled high, then drops the next cycle and sets aw_done or w_done.
  - Same-cycle AWREADY and WREADY completes both.
  - VALID never depends on READY.
  - When both are done, go to WR_RESP with BREADY_o=1.
  - WSTRB_o is all ones.
- WR_RESP: on BVALID_i&&BREADY_o, capture BRESP_i, drop BREADY_o, go to RSP.
- RD_REQ: hold ARVALID_o until ARREADY_i, then go to RD_DATA with RREADY_o=1.
- RD_DATA: on RVALID_i, capture RDATA_i/RRESP_i, drop RREADY_o, go to RSP.
- RSP: rsp_valid_o=1 with stable rsp_* fields until rsp_ready_i; then IDLE with cmd_ready_o=1 the following cycle.
- No command is accepted while not in IDLE.
- Minimum write latency against a zero-wait slave (cmd accept to rsp_valid_o): 4 cycles. Read latency is also 4 cycles.
- A BVALID_i or RVALID_i arriving before its request handshake completes is ignored until the FSM reaches WR_RESP or RD_DATA.
- Non-OKAY responses are passed through unchanged; the block does not retry.

Optional Feature:
- Macro: AXI_LITE_MST_TIMEOUT_EN.
- Defined:
  - A counter runs in every non-IDLE, non-RSP state and resets on each state change.
  - On reaching TIMEOUT_CYC it deasserts all AXI VALID/READY outputs and goes to RSP with rsp_resp_o=2'b10 and rsp_timeout_o=1.
- Undefined: no counter; rsp_timeout_o=0; the block waits forever.

Decomposition:
- Package axi_lite_pkg:
  - state enum (IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP);
  - resp constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
- One sub-module: axi_lite_mst_wdog (counter plus expire pulse), instantiated only under the macro.

Test Plan:
- Zero-wait slave, write addr 0x0000_0010 data 0xDEAD_BEEF -> AWADDR_o=0x10, WDATA_o=0xDEADBEEF, one beat each; rsp_resp_o=00 4 cycles after accept.
- AWREADY delayed 3 cycles, WREADY immediate -> WVALID_o drops after 1 cycle, AWVALID_o held 4 cycles; exactly one B handshake.
- Read addr 0x0000_0020, slave returns RDATA=0x1234_5678, RRESP=10 -> rsp_rdata_o=0x12345678, rsp_resp_o=10.
- rsp_ready_i held low 5 cycles -> rsp_valid_o and rsp fields stable; cmd_ready_o stays 0 until 1 cycle after rsp_ready_i.
- rst_n pulsed low while in WR_REQ -> all outputs 0 asynchronously; the next command is accepted normally.
- With AXI_LITE_MST_TIMEOUT_EN and TIMEOUT_CYC=16, slave never raises ARREADY -> after 16 cycles ARVALID_o=0, rsp_timeout_o=1, rsp_resp_o=10.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared types for the AXI4-Lite master slice.
// Holds the master FSM state encoding and the AXI response codes.
package axi_lite_pkg;

    // Master FSM states, one outstanding transaction at a time.
    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } state_e;

    // AXI BRESP/RRESP encodings.
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    // True for the two error encodings; handy for controllers consuming rsp_resp_o.
    function automatic logic resp_is_error(input logic [1:0] resp);
        return (resp == SLVERR) || (resp == DECERR);
    endfunction

endpackage

// File: rtl/axi_lite_mst_wdog.sv
// axi_lite_mst_wdog: per-state watchdog for axi_lite_mst.
// Instantiated only when AXI_LITE_MST_TIMEOUT_EN is defined.
// The count restarts whenever the master changes state or leaves the
// monitored states; expire is high during the TIMEOUT_CYC-th cycle spent
// in one monitored state.
module axi_lite_mst_wdog #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

    logic [CW-1:0] cnt_q;

    assign expire = en && (cnt_q == CW'(TIMEOUT_CYC - 1));

    // Cycle counter: cleared outside monitored states and on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || !en) begin
            cnt_q <= '0;
        end else if (!expire) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/axi_lite_mst.sv
// axi_lite_mst: AXI4-Lite master turning single-beat local commands into
// AXI-Lite write (AW+W then B) or read (AR then R) transactions, one at a
// time. Every output comes straight from a flop.
// Optional feature: define AXI_LITE_MST_TIMEOUT_EN to add a per-state
// watchdog that aborts a stuck transaction after TIMEOUT_CYC cycles with
// rsp_resp_o = SLVERR and rsp_timeout_o = 1.
module axi_lite_mst
    import axi_lite_pkg::*;
#(
    parameter int BW          = 32,
    parameter int AW          = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    // local command port
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_write_i,
    input  logic [AW-1:0]   cmd_addr_i,
    input  logic [BW-1:0]   cmd_wdata_i,
    // local response port
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [BW-1:0]   rsp_rdata_o,
    output logic [1:0]      rsp_resp_o,
    output logic            rsp_timeout_o,
    // write address channel
    output logic            AWVALID_o,
    input  logic            AWREADY_i,
    output logic [AW-1:0]   AWADDR_o,
    // write data channel
    output logic            WVALID_o,
    input  logic            WREADY_i,
    output logic [BW-1:0]   WDATA_o,
    output logic [BW/8-1:0] WSTRB_o,
    // write response channel
    input  logic            BVALID_i,
    output logic            BREADY_o,
    input  logic [1:0]      BRESP_i,
    // read address channel
    output logic            ARVALID_o,
    input  logic            ARREADY_i,
    output logic [AW-1:0]   ARADDR_o,
    // read data channel
    input  logic            RVALID_i,
    output logic            RREADY_o,
    input  logic [BW-1:0]   RDATA_i,
    input  logic [1:0]      RRESP_i
);

    state_e        state_q, state_d;

    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [BW-1:0] wdata_q, wdata_d;
    logic [BW-1:0] rdata_q, rdata_d;
    logic [1:0]    resp_q, resp_d;
    logic          timeout_q, timeout_d;

    logic          cmd_ready_q, cmd_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          bready_q, bready_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;

    logic          wdog_expire;

`ifdef AXI_LITE_MST_TIMEOUT_EN
    logic wdog_en;
    logic wdog_clr;

    assign wdog_en  = (state_q != IDLE) && (state_q != RSP);
    assign wdog_clr = (state_d != state_q);

    axi_lite_mst_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (wdog_en),
        .clr    (wdog_clr),
        .expire (wdog_expire)
    );
`else
    logic unused_timeout_cyc;

    assign wdog_expire        = 1'b0;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

    // Next state, captured fields and next registered outputs.
    // NOTE: every variable gets its default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        timeout_d   = timeout_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    addr_d    = cmd_addr_i;
                    wdata_d   = cmd_wdata_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    rdata_d   = '0;
                    resp_d    = OKAY;
                    timeout_d = 1'b0;
                    state_d   = cmd_write_i ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                // AW and W complete independently; same-cycle readies finish both.
                aw_done_d = aw_done_q || (awvalid_q && AWREADY_i);
                w_done_d  = w_done_q  || (wvalid_q  && WREADY_i);
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bready_q && BVALID_i) begin
                    resp_d  = BRESP_i;
                    state_d = RSP;
                end
            end
            RD_REQ: begin
                if (arvalid_q && ARREADY_i) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rready_q && RVALID_i) begin
                    rdata_d = RDATA_i;
                    resp_d  = RRESP_i;
                    state_d = RSP;
                end
            end
            RSP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A stuck request or response phase is abandoned as a slave error.
        if (wdog_expire) begin
            state_d   = RSP;
            rdata_d   = '0;
            resp_d    = SLVERR;
            timeout_d = 1'b1;
        end

        // Outputs are decoded from the next state so they leave a flop directly.
        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RSP);
        awvalid_d   = (state_d == WR_REQ) && !aw_done_d;
        wvalid_d    = (state_d == WR_REQ) && !w_done_d;
        bready_d    = (state_d == WR_RESP);
        arvalid_d   = (state_d == RD_REQ);
        rready_d    = (state_d == RD_DATA);
    end

    // State register.
    // NOTE: sequential blocks use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and handshake output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= OKAY;
            timeout_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            timeout_q   <= timeout_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rdata_q;
    assign rsp_resp_o    = resp_q;
    assign rsp_timeout_o = timeout_q;

    assign AWVALID_o     = awvalid_q;
    assign AWADDR_o      = addr_q;
    assign WVALID_o      = wvalid_q;
    assign WDATA_o       = wdata_q;
    assign WSTRB_o       = '1;
    assign BREADY_o      = bready_q;
    assign ARVALID_o     = arvalid_q;
    assign ARADDR_o      = addr_q;
    assign RREADY_o      = rready_q;

endmodule

// File: tb/tb_axi_lite_mst.sv
// tb_axi_lite_mst: self-checking bench for axi_lite_mst.
// A behavioural AXI-Lite slave with programmable per-channel wait states
// answers the master; expected response fields, handshake counts and the
// command-accept-to-response latency are derived from the planned slave
// behaviour with plain arithmetic. Define AXI_LITE_MST_TIMEOUT_EN to also
// exercise the watchdog abort (TIMEOUT_CYC = 16).
module tb_axi_lite_mst;
    import axi_lite_pkg::*;

    localparam int BW = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cmd_valid_i = 1'b0;
    logic            cmd_ready_o;
    logic            cmd_write_i = 1'b0;
    logic [AW-1:0]   cmd_addr_i = '0;
    logic [BW-1:0]   cmd_wdata_i = '0;
    logic            rsp_valid_o;
    logic            rsp_ready_i = 1'b0;
    logic [BW-1:0]   rsp_rdata_o;
    logic [1:0]      rsp_resp_o;
    logic            rsp_timeout_o;
    logic            AWVALID_o;
    logic            AWREADY_i = 1'b0;
    logic [AW-1:0]   AWADDR_o;
    logic            WVALID_o;
    logic            WREADY_i = 1'b0;
    logic [BW-1:0]   WDATA_o;
    logic [BW/8-1:0] WSTRB_o;
    logic            BVALID_i = 1'b0;
    logic            BREADY_o;
    logic [1:0]      BRESP_i = 2'b00;
    logic            ARVALID_o;
    logic            ARREADY_i = 1'b0;
    logic [AW-1:0]   ARADDR_o;
    logic            RVALID_i = 1'b0;
    logic            RREADY_o;
    logic [BW-1:0]   RDATA_i = '0;
    logic [1:0]      RRESP_i = 2'b00;

    int n_checks = 0;
    int n_fail   = 0;

    // slave plan
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    bit          b_early = 1'b0, ar_never = 1'b0;
    logic [1:0]  b_resp_plan = OKAY, r_resp_plan = OKAY;
    logic [31:0] r_data_plan = '0;

    // slave observations and wait counters (cleared per transaction)
    int          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    int          awv_cycles, wv_cycles, arv_cycles;
    logic [31:0] seen_awaddr, seen_wdata, seen_araddr;

    always #5 clk = ~clk;

    axi_lite_mst #(
        .BW          (BW),
        .AW          (AW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_write_i   (cmd_write_i),
        .cmd_addr_i    (cmd_addr_i),
        .cmd_wdata_i   (cmd_wdata_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_resp_o    (rsp_resp_o),
        .rsp_timeout_o (rsp_timeout_o),
        .AWVALID_o     (AWVALID_o),
        .AWREADY_i     (AWREADY_i),
        .AWADDR_o      (AWADDR_o),
        .WVALID_o      (WVALID_o),
        .WREADY_i      (WREADY_i),
        .WDATA_o       (WDATA_o),
        .WSTRB_o       (WSTRB_o),
        .BVALID_i      (BVALID_i),
        .BREADY_o      (BREADY_o),
        .BRESP_i       (BRESP_i),
        .ARVALID_o     (ARVALID_o),
        .ARREADY_i     (ARREADY_i),
        .ARADDR_o      (ARADDR_o),
        .RVALID_i      (RVALID_i),
        .RREADY_o      (RREADY_o),
        .RDATA_i       (RDATA_i),
        .RRESP_i       (RRESP_i)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Main-thread step: act 2 time units after the falling edge.
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_slave_stats();
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        awv_cycles = 0; wv_cycles = 0; arv_cycles = 0;
        seen_awaddr = '0; seen_wdata = '0; seen_araddr = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {cmd_ready_o, rsp_valid_o, rsp_timeout_o, AWVALID_o, WVALID_o,
                               BREADY_o, ARVALID_o, RREADY_o, rsp_resp_o}, 64'd0);
        check({tag, "_aw_w"}, {AWADDR_o, WDATA_o}, 64'd0);
        check({tag, "_ar_rsp"}, {ARADDR_o, rsp_rdata_o}, 64'd0);
    endtask

    // Behavioural slave: decides READY/VALID at each falling edge, and
    // recognises the handshakes that completed at the rising edge just passed.
    initial begin : slave
        logic        p_awv, p_wv, p_bready, p_arv, p_rready;
        logic [31:0] p_awaddr, p_wdata, p_araddr;
        p_awv = 0; p_wv = 0; p_bready = 0; p_arv = 0; p_rready = 0;
        p_awaddr = '0; p_wdata = '0; p_araddr = '0;
        clear_slave_stats();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                AWREADY_i = 0; WREADY_i = 0; BVALID_i = 0; ARREADY_i = 0; RVALID_i = 0;
                p_awv = 0; p_wv = 0; p_bready = 0; p_arv = 0; p_rready = 0;
                clear_slave_stats();
            end else begin
                if (p_awv && AWREADY_i) begin aw_hs++; seen_awaddr = p_awaddr; aw_cnt = 0; end
                if (p_wv && WREADY_i) begin w_hs++; seen_wdata = p_wdata; w_cnt = 0; end
                if (BVALID_i && p_bready) begin b_hs++; BVALID_i = 0; end
                if (p_arv && ARREADY_i) begin ar_hs++; seen_araddr = p_araddr; ar_cnt = 0; end
                if (RVALID_i && p_rready) begin r_hs++; RVALID_i = 0; end

                if (b_hs == 0 && ((aw_hs == 1 && w_hs == 1) || (b_early && (AWVALID_o || WVALID_o)))) begin
                    if (b_early || b_cnt >= b_dly) begin
                        BVALID_i = 1; BRESP_i = b_resp_plan;
                    end
                    b_cnt++;
                end
                if (ar_hs == 1 && r_hs == 0) begin
                    if (r_cnt >= r_dly) begin
                        RVALID_i = 1; RDATA_i = r_data_plan; RRESP_i = r_resp_plan;
                    end
                    r_cnt++;
                end

                AWREADY_i = AWVALID_o && (aw_cnt >= aw_dly);
                WREADY_i  = WVALID_o && (w_cnt >= w_dly);
                ARREADY_i = ARVALID_o && !ar_never && (ar_cnt >= ar_dly);
                if (AWVALID_o) begin aw_cnt++; awv_cycles++; end
                if (WVALID_o)  begin w_cnt++;  wv_cycles++;  end
                if (ARVALID_o) begin ar_cnt++; arv_cycles++; end

                p_awv = AWVALID_o; p_awaddr = AWADDR_o;
                p_wv = WVALID_o; p_wdata = WDATA_o;
                p_bready = BREADY_o;
                p_arv = ARVALID_o; p_araddr = ARADDR_o;
                p_rready = RREADY_o;
            end
        end
    end

    // One command end to end. Latency is counted in cycles after the accept
    // cycle (accept = cycle 0): a zero-wait slave yields rsp_valid_o in cycle 3,
    // the fourth cycle counting the accept cycle.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                           input int hold, input bit expect_to);
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_lat;
        int          lat;
        int          waits;
        if (expect_to) begin
            exp_rdata = '0; exp_resp = SLVERR; exp_lat = TO + 1;
        end else if (wr) begin
            exp_rdata = '0; exp_resp = b_resp_plan;
            exp_lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + (b_early ? 0 : b_dly);
        end else begin
            exp_rdata = r_data_plan; exp_resp = r_resp_plan;
            exp_lat = 3 + ar_dly + r_dly;
        end

        waits = 0;
        while (!cmd_ready_o && waits < 20) begin tick(); waits++; end
        check("cmd_ready_idle", cmd_ready_o, 1);

        clear_slave_stats();
        cmd_valid_i = 1; cmd_write_i = wr; cmd_addr_i = addr; cmd_wdata_i = data;
        tick();
        cmd_valid_i = 0; cmd_write_i = 0; cmd_addr_i = $urandom; cmd_wdata_i = $urandom;

        lat = 1;
        while (!rsp_valid_o && lat < 200) begin tick(); lat++; end
        check("rsp_latency", lat, exp_lat);

        for (int i = 0; i <= hold; i++) begin
            check("rsp_valid", rsp_valid_o, 1);
            check("rsp_rdata", rsp_rdata_o, exp_rdata);
            check("rsp_resp", rsp_resp_o, exp_resp);
            check("rsp_timeout", rsp_timeout_o, expect_to);
            check("cmd_ready_busy", cmd_ready_o, 0);
            if (i < hold) tick();
        end
        rsp_ready_i = 1;
        tick();
        rsp_ready_i = 0;
        check("rsp_valid_after_pop", rsp_valid_o, 0);
        check("cmd_ready_after_pop", cmd_ready_o, 1);

        if (expect_to) begin
            check("to_handshakes", {aw_hs[7:0], w_hs[7:0], b_hs[7:0], ar_hs[7:0], r_hs[7:0]}, 64'd0);
        end else if (wr) begin
            check("wr_handshakes", {aw_hs[7:0], w_hs[7:0], b_hs[7:0], ar_hs[7:0], r_hs[7:0]},
                  64'h01_01_01_00_00);
            check("wr_addr_data", {seen_awaddr, seen_wdata}, {addr, data});
        end else begin
            check("rd_handshakes", {aw_hs[7:0], w_hs[7:0], b_hs[7:0], ar_hs[7:0], r_hs[7:0]},
                  64'h00_00_00_01_01);
            check("rd_addr", seen_araddr, addr);
        end
    endtask

    task automatic set_plan(input int daw, input int dw, input int db, input int dar, input int dr);
        aw_dly = daw; w_dly = dw; b_dly = db; ar_dly = dar; r_dly = dr;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL sim_timeout: time limit reached, summary not printed");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        logic [31:0] a, d;
        bit          wr;
        int          hold;

        // reset state
        tick(); tick();
        check_reset_outputs("reset");
        rst_n = 1;

        // zero-wait write
        set_plan(0, 0, 0, 0, 0); b_resp_plan = OKAY;
        run_txn(1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0);
        check("wstrb", WSTRB_o, 4'hF);
        check("zw_valid_cycles", {awv_cycles[15:0], wv_cycles[15:0]}, {16'd1, 16'd1});

        // AWREADY 3 cycles late, WREADY immediate
        set_plan(3, 0, 0, 0, 0); b_resp_plan = EXOKAY;
        run_txn(1, 32'h0000_0044, 32'hA5A5_0F0F, 0, 0);
        check("awdly_valid_cycles", {awv_cycles[15:0], wv_cycles[15:0]}, {16'd4, 16'd1});

        // read with SLVERR passthrough
        set_plan(0, 0, 0, 0, 0); r_resp_plan = SLVERR; r_data_plan = 32'h1234_5678;
        run_txn(0, 32'h0000_0020, 32'h0, 0, 0);

        // response held off for 5 cycles
        set_plan(0, 0, 0, 1, 2); r_resp_plan = OKAY; r_data_plan = 32'hCAFE_F00D;
        run_txn(0, 32'h0000_0100, 32'h0, 5, 0);

        // BVALID raised before the request handshakes, W slower than AW
        set_plan(0, 2, 0, 0, 0); b_early = 1; b_resp_plan = DECERR;
        run_txn(1, 32'h0000_0200, 32'h0BAD_F00D, 0, 0);
        b_early = 0;

        // randomised traffic
        for (int n = 0; n < 16; n++) begin
            wr   = 1'($urandom_range(0, 1));
            a    = $urandom;
            d    = $urandom;
            hold = $urandom_range(0, 3);
            set_plan($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3));
            b_resp_plan = 2'($urandom_range(0, 3));
            r_resp_plan = 2'($urandom_range(0, 3));
            r_data_plan = $urandom;
            run_txn(wr, a, d, hold, 0);
        end

        // asynchronous reset while the write address phase is stalled
        set_plan(10, 0, 0, 0, 0);
        clear_slave_stats();
        cmd_valid_i = 1; cmd_write_i = 1; cmd_addr_i = 32'h0000_0300; cmd_wdata_i = 32'h1111_2222;
        tick();
        cmd_valid_i = 0;
        tick();
        check("pre_reset_awvalid", AWVALID_o, 1);
        #1 rst_n = 0;
        #1;
        check_reset_outputs("async_reset");
        tick();
        rst_n = 1;
        check("reset_no_rsp", rsp_valid_o, 0);
        set_plan(0, 0, 0, 0, 0); b_resp_plan = OKAY;
        run_txn(1, 32'h0000_0304, 32'h3333_4444, 0, 0);

`ifdef AXI_LITE_MST_TIMEOUT_EN
        // slave never grants AR: watchdog abort
        ar_never = 1;
        run_txn(0, 32'h0000_0400, 32'h0, 1, 1);
        check("to_arvalid_cycles", arv_cycles, TO);
        ar_never = 0;
        r_resp_plan = OKAY; r_data_plan = 32'h5555_AAAA;
        run_txn(0, 32'h0000_0404, 32'h0, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
